mem_arbiter: RTL and testbench

Sequencing controller for a single-port unified memory shared between the pipelined core's fetch stage and memory stage. It accepts requests from both ports and grants one at a time, data port first, with an optional starvation guard. It drives the memory address, write and byte controls for a configurable access latency and returns read data with a one-cycle valid pulse. It produces per-stage stall signals that the pipeline registers use as enables.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data ports: data-first grant, fixed access latency, per-stage stalls.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    input  logic                  d_byte_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_f_o,
    output logic                  stall_m_o,
    output logic [1:0]            dbgState
);

    // Handshake: a requester holds req and its fields until gnt (a single cycle in IDLE);
    // after gnt it may change inputs, and rvalid pulses for one cycle when the access completes.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } stateT;

    stateT      state;
    logic [3:0] latCnt;
    logic       ownerData;
    logic       forceFetch;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starveCnt;

    assign forceFetch = (starveCnt == 4'(STARVE_LIMIT)) && if_req_i && d_req_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= 4'd0;
        end else if (if_gnt_o || (state == IDLE && !if_req_i)) begin
            starveCnt <= 4'd0;
        end else if (d_gnt_o && if_req_i && starveCnt != 4'hF) begin
            starveCnt <= starveCnt + 4'd1;
        end
    end
`else
    assign forceFetch = 1'b0;
`endif

    // The data port carries the older instruction, so it wins unless the guard forces fetch.
    assign d_gnt_o  = (state == IDLE) && d_req_i && !forceFetch;
    assign if_gnt_o = (state == IDLE) && if_req_i && (!d_req_i || forceFetch);

    assign stall_m_o = d_req_i & ~d_rvalid_o;
    assign stall_f_o = (if_req_i & ~if_rvalid_o) | stall_m_o;
    assign dbgState  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            latCnt      <= 4'd0;
            ownerData   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            mem_byte_o  <= 1'b0;
            if_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            d_rvalid_o  <= 1'b0;
            d_rdata_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_gnt_o || if_gnt_o) begin
                        ownerData   <= d_gnt_o;
                        mem_addr_o  <= d_gnt_o ? d_addr_i : if_addr_i;
                        mem_wdata_o <= d_gnt_o ? d_wdata_i : '0;
                        mem_we_o    <= d_gnt_o & d_we_i;
                        mem_byte_o  <= d_gnt_o & d_byte_i;
                        latCnt      <= 4'(MEM_LATENCY);
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (latCnt == 4'd1) begin
                        // mem_we_o still holds the latched store flag here.
                        if (ownerData) begin
                            d_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
                        end else begin
                            if_rdata_o <= mem_rdata_i;
                        end
                        d_rvalid_o  <= ownerData;
                        if_rvalid_o <= !ownerData;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        mem_we_o    <= 1'b0;
                        mem_byte_o  <= 1'b0;
                        latCnt      <= 4'd0;
                        state       <= RESP;
                    end else begin
                        latCnt <= latCnt - 4'd1;
                    end
                end
                RESP: begin
                    d_rvalid_o  <= 1'b0;
                    if_rvalid_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LATENCY=1 (index 0), one with MEM_LATENCY=3 (index 1).
// Starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

    localparam int L1 = 0;
    localparam int L3 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        dByte;
    logic [31:0] memRdata;

    logic        ifGnt    [2];
    logic        ifRvalid [2];
    logic [31:0] ifRdata  [2];
    logic        dGnt     [2];
    logic        dRvalid  [2];
    logic [31:0] dRdata   [2];
    logic [31:0] memAddr  [2];
    logic [31:0] memWdata [2];
    logic        memWe    [2];
    logic        memByte  [2];
    logic        stallF   [2];
    logic        stallM   [2];
    logic [1:0]  dbgState [2];

    int nCompared   = 0;
    int nMismatched = 0;
    logic [31:0] expQ[$];

    // Clock and reset
    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dutLat1 (
        .clk(clk), .rst(rst),
        .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt[L1]),
        .if_rvalid_o(ifRvalid[L1]), .if_rdata_o(ifRdata[L1]),
        .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_byte_i(dByte),
        .d_gnt_o(dGnt[L1]), .d_rvalid_o(dRvalid[L1]), .d_rdata_o(dRdata[L1]),
        .mem_addr_o(memAddr[L1]), .mem_wdata_o(memWdata[L1]), .mem_we_o(memWe[L1]),
        .mem_byte_o(memByte[L1]), .mem_rdata_i(memRdata),
        .stall_f_o(stallF[L1]), .stall_m_o(stallM[L1]), .dbgState(dbgState[L1])
    );

    mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dutLat3 (
        .clk(clk), .rst(rst),
        .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt[L3]),
        .if_rvalid_o(ifRvalid[L3]), .if_rdata_o(ifRdata[L3]),
        .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_byte_i(dByte),
        .d_gnt_o(dGnt[L3]), .d_rvalid_o(dRvalid[L3]), .d_rdata_o(dRdata[L3]),
        .mem_addr_o(memAddr[L3]), .mem_wdata_o(memWdata[L3]), .mem_we_o(memWe[L3]),
        .mem_byte_o(memByte[L3]), .mem_rdata_i(memRdata),
        .stall_f_o(stallF[L3]), .stall_m_o(stallM[L3]), .dbgState(dbgState[L3])
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst      = 1'b0;
        ifReq    = 1'b0;
        ifAddr   = '0;
        dReq     = 1'b0;
        dWe      = 1'b0;
        dAddr    = '0;
        dWdata   = '0;
        dByte    = 1'b0;
        memRdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        nMismatched++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        logic seq [8];
        int   nGrant;
        int   nBoth;
        int   nFetch;
        int   nIfGnt;
        int   nIfRv;
        int   nDRv;
        logic dropD;

        // Reset state
        doReset();
        @(negedge clk);
        checkVal("rst_state", 32'(dbgState[L1]), 32'd0);
        checkVal("rst_if_gnt", 32'(ifGnt[L1]), 32'd0);
        checkVal("rst_d_gnt", 32'(dGnt[L1]), 32'd0);
        checkVal("rst_if_rvalid", 32'(ifRvalid[L1]), 32'd0);
        checkVal("rst_d_rvalid", 32'(dRvalid[L1]), 32'd0);
        checkVal("rst_if_rdata", ifRdata[L1], 32'd0);
        checkVal("rst_d_rdata", dRdata[L1], 32'd0);
        checkVal("rst_mem_addr", memAddr[L1], 32'd0);
        checkVal("rst_mem_wdata", memWdata[L1], 32'd0);
        checkVal("rst_mem_we", 32'(memWe[L1]), 32'd0);
        checkVal("rst_mem_byte", 32'(memByte[L1]), 32'd0);
        checkVal("rst_stall_f", 32'(stallF[L1]), 32'd0);
        checkVal("rst_stall_m", 32'(stallM[L1]), 32'd0);

        // Single fetch, latency 1
        doReset();
        ifReq = 1'b1; ifAddr = 32'h0000_0010; memRdata = 32'h00A0_0513;
        expQ.push_back(32'h00A0_0513);
        @(negedge clk);
        checkVal("f_gnt_c0", 32'(ifGnt[L1]), 32'd1);
        checkVal("f_dgnt_c0", 32'(dGnt[L1]), 32'd0);
        checkVal("f_stall_f_c0", 32'(stallF[L1]), 32'd1);
        cyc();
        @(negedge clk);
        checkVal("f_state_c1", 32'(dbgState[L1]), 32'd1);
        checkVal("f_mem_addr_c1", memAddr[L1], 32'h10);
        checkVal("f_mem_we_c1", 32'(memWe[L1]), 32'd0);
        checkVal("f_gnt_c1", 32'(ifGnt[L1]), 32'd0);
        checkVal("f_stall_f_c1", 32'(stallF[L1]), 32'd1);
        cyc();
        @(negedge clk);
        checkVal("f_rvalid_c2", 32'(ifRvalid[L1]), 32'd1);
        checkVal("f_rdata_c2", ifRdata[L1], expQ.pop_front());
        checkVal("f_stall_f_c2", 32'(stallF[L1]), 32'd0);
        checkVal("f_gnt_c2", 32'(ifGnt[L1]), 32'd0);
        cyc();
        ifReq = 1'b0;
        @(negedge clk);
        checkVal("f_rvalid_c3", 32'(ifRvalid[L1]), 32'd0);
        checkVal("f_rdata_hold", ifRdata[L1], 32'h00A0_0513);

        // Simultaneous store and fetch, latency 1
        doReset();
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h100; dWdata = 32'hDEAD_BEEF;
        ifReq = 1'b1; ifAddr = 32'h14; memRdata = 32'h1234_5678;
        @(negedge clk);
        checkVal("s_dgnt_c0", 32'(dGnt[L1]), 32'd1);
        checkVal("s_ifgnt_c0", 32'(ifGnt[L1]), 32'd0);
        checkVal("s_stall_m_c0", 32'(stallM[L1]), 32'd1);
        checkVal("s_stall_f_c0", 32'(stallF[L1]), 32'd1);
        cyc();
        @(negedge clk);
        checkVal("s_we_c1", 32'(memWe[L1]), 32'd1);
        checkVal("s_addr_c1", memAddr[L1], 32'h100);
        checkVal("s_wdata_c1", memWdata[L1], 32'hDEAD_BEEF);
        checkVal("s_ifgnt_c1", 32'(ifGnt[L1]), 32'd0);
        cyc();
        @(negedge clk);
        checkVal("s_we_c2", 32'(memWe[L1]), 32'd0);
        checkVal("s_drvalid_c2", 32'(dRvalid[L1]), 32'd1);
        checkVal("s_drdata_c2", dRdata[L1], 32'd0);
        checkVal("s_stall_m_c2", 32'(stallM[L1]), 32'd0);
        checkVal("s_stall_f_c2", 32'(stallF[L1]), 32'd1);
        checkVal("s_ifgnt_c2", 32'(ifGnt[L1]), 32'd0);
        cyc();
        dReq = 1'b0; dWe = 1'b0;
        @(negedge clk);
        checkVal("s_ifgnt_c3", 32'(ifGnt[L1]), 32'd1);
        checkVal("s_dgnt_c3", 32'(dGnt[L1]), 32'd0);
        checkVal("s_drvalid_c3", 32'(dRvalid[L1]), 32'd0);
        cyc();
        memRdata = 32'hCAFE_F00D;
        expQ.push_back(32'hCAFE_F00D);
        @(negedge clk);
        checkVal("s_addr_c4", memAddr[L1], 32'h14);
        checkVal("s_we_c4", 32'(memWe[L1]), 32'd0);
        cyc();
        @(negedge clk);
        checkVal("s_ifrvalid_c5", 32'(ifRvalid[L1]), 32'd1);
        checkVal("s_ifrdata_c5", ifRdata[L1], expQ.pop_front());
        cyc();
        ifReq = 1'b0;

        // Byte load, latency 3
        doReset();
        dReq = 1'b1; dWe = 1'b0; dByte = 1'b1; dAddr = 32'h101;
        ifReq = 1'b1; ifAddr = 32'h18; memRdata = 32'hFFFF_FFFF;
        expQ.push_back(32'h0000_00AB);
        @(negedge clk);
        checkVal("b_dgnt_c0", 32'(dGnt[L3]), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c == 3) memRdata = 32'h0000_00AB;
            @(negedge clk);
            checkVal($sformatf("b_byte_c%0d", c), 32'(memByte[L3]), 32'd1);
            checkVal($sformatf("b_addr_c%0d", c), memAddr[L3], 32'h101);
            checkVal($sformatf("b_we_c%0d", c), 32'(memWe[L3]), 32'd0);
            checkVal($sformatf("b_drvalid_c%0d", c), 32'(dRvalid[L3]), 32'd0);
            checkVal($sformatf("b_stall_m_c%0d", c), 32'(stallM[L3]), 32'd1);
            checkVal($sformatf("b_stall_f_c%0d", c), 32'(stallF[L3]), 32'd1);
        end
        cyc();
        @(negedge clk);
        checkVal("b_drvalid_c4", 32'(dRvalid[L3]), 32'd1);
        checkVal("b_drdata_c4", dRdata[L3], expQ.pop_front());
        checkVal("b_byte_c4", 32'(memByte[L3]), 32'd0);
        checkVal("b_stall_m_c4", 32'(stallM[L3]), 32'd0);
        cyc();
        dReq = 1'b0; ifReq = 1'b0; dByte = 1'b0;
        @(negedge clk);
        checkVal("b_drvalid_c5", 32'(dRvalid[L3]), 32'd0);

        // Continuous data requests with fetch pending, latency 1
        doReset();
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h300;
        ifReq = 1'b1; ifAddr = 32'h40;
        nGrant = 0; nBoth = 0; nFetch = 0;
        for (int i = 0; i < 8; i++) seq[i] = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (dGnt[L1] && ifGnt[L1]) nBoth++;
            if ((dGnt[L1] || ifGnt[L1]) && nGrant < 8) begin
                seq[nGrant] = ifGnt[L1];
                if (ifGnt[L1]) nFetch++;
                nGrant++;
            end
            cyc();
        end
        checkVal("st_grants", 32'(nGrant), 32'd6);
        checkVal("st_both", 32'(nBoth), 32'd0);
        checkVal("st_first_data", 32'(seq[0]), 32'd0);
        checkVal("st_fourth_data", 32'(seq[3]), 32'd0);
`ifdef ARB_STARVE_GUARD_EN
        checkVal("st_fifth_owner", 32'(seq[4]), 32'd1);
        checkVal("st_fetch_grants", 32'(nFetch), 32'd1);
`else
        checkVal("st_fifth_owner", 32'(seq[4]), 32'd0);
        checkVal("st_fetch_grants", 32'(nFetch), 32'd0);
`endif
        dReq = 1'b0; ifReq = 1'b0;

        // Reset asserted during a store access, latency 3
        doReset();
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h200; dWdata = 32'h55AA_55AA;
        @(negedge clk);
        checkVal("r_dgnt_c0", 32'(dGnt[L3]), 32'd1);
        cyc();
        dReq = 1'b0; dWe = 1'b0;
        @(negedge clk);
        checkVal("r_we_c1", 32'(memWe[L3]), 32'd1);
        cyc();
        #2;
        rst = 1'b0;
        #1;
        checkVal("r_we_async", 32'(memWe[L3]), 32'd0);
        checkVal("r_addr_async", memAddr[L3], 32'd0);
        checkVal("r_state_async", 32'(dbgState[L3]), 32'd0);
        cyc();
        rst = 1'b1;
        nDRv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dRvalid[L3] || ifRvalid[L3]) nDRv++;
            cyc();
        end
        checkVal("r_no_rvalid", 32'(nDRv), 32'd0);
        @(negedge clk);
        checkVal("r_state_after", 32'(dbgState[L3]), 32'd0);
        checkVal("r_we_after", 32'(memWe[L3]), 32'd0);
        checkVal("r_wdata_after", memWdata[L3], 32'd0);
        checkVal("r_drdata_after", dRdata[L3], 32'd0);

        // Fetch withdrawn right after data wins, latency 1
        doReset();
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h80;
        ifReq = 1'b1; ifAddr = 32'h44; memRdata = 32'h1111_2222;
        @(negedge clk);
        checkVal("w_dgnt_c0", 32'(dGnt[L1]), 32'd1);
        checkVal("w_ifgnt_c0", 32'(ifGnt[L1]), 32'd0);
        cyc();
        ifReq = 1'b0;
        nIfGnt = 0; nIfRv = 0; nDRv = 0; dropD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifGnt[L1]) nIfGnt++;
            if (ifRvalid[L1]) nIfRv++;
            if (dRvalid[L1]) begin
                nDRv++;
                dropD = 1'b1;
            end
            cyc();
            if (dropD) dReq = 1'b0;
        end
        checkVal("w_if_gnts", 32'(nIfGnt), 32'd0);
        checkVal("w_if_rvalids", 32'(nIfRv), 32'd0);
        checkVal("w_d_rvalids", 32'(nDRv), 32'd1);
        checkVal("w_d_rdata", dRdata[L1], 32'h1111_2222);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
